// File: rtl/pwm_3bit_schematic_if.sv
// Control, duty and output signals of the 3-bit PWM block.
// The controller drives through the master modport; the PWM block uses the slave modport.
interface pwm_3bit_schematic_if;
    logic CE;
    logic JK;
    logic CLR_JK;
    logic INPUT_1;
    logic INPUT_2;
    logic INPUT_3;
    logic INPUT_4;
    logic OUTPUT_1;

    modport master (
        output CE, JK, CLR_JK, INPUT_1, INPUT_2, INPUT_3, INPUT_4,
        input  OUTPUT_1
    );

    modport slave (
        input  CE, JK, CLR_JK, INPUT_1, INPUT_2, INPUT_3, INPUT_4,
        output OUTPUT_1
    );
endinterface

// File: rtl/pwm_3bit_schematic.sv
// 3-bit PWM: free-running mod-8 counter driving a JK output flop, duty = D/8.
// Optional macro PWM_DUTY_SHADOW_EN latches the duty value at period boundaries.
module pwm_3bit_schematic #(
    parameter logic [2:0] INIT_DUTY = 3'd0
) (
    input logic                  Clock,
    input logic                  CLR_CNTR,
    pwm_3bit_schematic_if.slave  bus
);
    logic [2:0] cnt;
    logic [2:0] nxt;
    logic [2:0] duty;
    logic [2:0] deff;
    logic       q;
    logic       j;
    logic       k;

`ifdef PWM_DUTY_SHADOW_EN
    logic [2:0] shadow;

    always_ff @(posedge Clock or posedge CLR_CNTR) begin
        if (CLR_CNTR) begin
            shadow <= INIT_DUTY;
        end else if (bus.CE && (cnt == 3'd7)) begin
            shadow <= duty;
        end
    end
`else
    logic unused_init_duty;
    assign unused_init_duty = ^INIT_DUTY;
`endif

    always_comb begin
        duty = {bus.INPUT_3, bus.INPUT_2, bus.INPUT_1};
        nxt  = cnt + 3'd1;
`ifdef PWM_DUTY_SHADOW_EN
        // Live duty is used on the wrap edge so the new period starts with the new value.
        deff = (cnt == 3'd7) ? duty : shadow;
`else
        deff = duty;
`endif
        j = (nxt == 3'd0) && (deff != 3'd0);
        k = (nxt == deff);
    end

    always_ff @(posedge Clock or posedge CLR_CNTR) begin
        if (CLR_CNTR) begin
            cnt <= 3'd0;
            q   <= 1'b0;
        end else begin
            if (bus.CE) begin
                cnt <= nxt;
            end
            if (bus.CLR_JK) begin
                q <= 1'b0;
            end else if (bus.CE && bus.JK) begin
                if (j) begin
                    q <= 1'b1;
                end else if (k) begin
                    q <= 1'b0;
                end
            end
        end
    end

    assign bus.OUTPUT_1 = q ^ bus.INPUT_4;
endmodule

// File: tb/tb_pwm_3bit_schematic.sv
// Self-checking bench for pwm_3bit_schematic: directed waveform checks plus randomized
// stimulus against a period-level reference model.
module tb_pwm_3bit_schematic;
    logic Clock;
    logic CLR_CNTR;
    int   tests;
    int   fails;

    int   m_cnt;
    int   m_q;
    int   m_sh;

    pwm_3bit_schematic_if bus ();

    pwm_3bit_schematic #(.INIT_DUTY(3'd0)) dut (
        .Clock    (Clock),
        .CLR_CNTR (CLR_CNTR),
        .bus      (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic set_duty(input int d);
        {bus.INPUT_3, bus.INPUT_2, bus.INPUT_1} = 3'(d);
    endtask

    function automatic int cur_duty();
        return int'({bus.INPUT_3, bus.INPUT_2, bus.INPUT_1});
    endfunction

    function automatic logic model_out();
        return logic'(m_q[0] ^ bus.INPUT_4);
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_q   = 0;
        m_sh  = 0;
    endtask

    // One clock edge with the inputs currently applied.
    task automatic model_edge();
        int d;
        int deff;
        int n;
        d    = cur_duty();
        deff = d;
`ifdef PWM_DUTY_SHADOW_EN
        deff = (m_cnt == 7) ? d : m_sh;
`endif
        n = (m_cnt + 1) % 8;
        if (bus.CLR_JK) begin
            m_q = 0;
        end else if (bus.CE && bus.JK) begin
            if (n == 0)         m_q = (deff != 0) ? 1 : 0;
            else if (n == deff) m_q = 0;
        end
        if (bus.CE) begin
            if (m_cnt == 7) m_sh = d;
            m_cnt = n;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        CLR_CNTR = 1'b1;
        #10;
        model_reset();
        CLR_CNTR = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        bus.CE = 1'b0; bus.JK = 1'b1; bus.CLR_JK = 1'b0; bus.INPUT_4 = 1'b0;
        set_duty(3);
        CLR_CNTR = 1'b1;
        #10;
        tests++;
        if (bus.OUTPUT_1 !== 1'b0) begin
            fails++; $display("FAIL reset_out pol0: got %b want 0", bus.OUTPUT_1);
        end
        bus.INPUT_4 = 1'b1;
        #1;
        tests++;
        if (bus.OUTPUT_1 !== 1'b1) begin
            fails++; $display("FAIL reset_out pol1: got %b want 1", bus.OUTPUT_1);
        end
        bus.INPUT_4 = 1'b0;
        model_reset();
        CLR_CNTR = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            tests++;
            if (bus.OUTPUT_1 !== 1'b0) begin
                fails++; $display("FAIL reset_static cycle %0d: got %b want 0", i, bus.OUTPUT_1);
            end
        end
    endtask

    // From reset, the first wrap is 8 edges away; afterwards Q is high exactly while cnt < D.
    task automatic test_pattern(input int d, input logic pol);
        bus.CE = 1'b1; bus.JK = 1'b1; bus.CLR_JK = 1'b0; bus.INPUT_4 = pol;
        set_duty(d);
        do_reset();
        for (int i = 0; i < 7; i++) begin
            tick();
            tests++;
            if (bus.OUTPUT_1 !== pol) begin
                fails++; $display("FAIL first_period d=%0d cycle %0d: got %b want %b", d, i, bus.OUTPUT_1, pol);
            end
        end
        for (int i = 0; i < 16; i++) begin
            logic exp_o;
            tick();
            exp_o = logic'((i % 8) < d) ^ pol;
            tests++;
            if (bus.OUTPUT_1 !== exp_o) begin
                fails++; $display("FAIL pattern d=%0d pol=%b phase %0d: got %b want %b", d, pol, i % 8, bus.OUTPUT_1, exp_o);
            end
        end
    endtask

    task automatic test_controls();
        bus.CE = 1'b1; bus.JK = 1'b1; bus.CLR_JK = 1'b0; bus.INPUT_4 = 1'b0;
        set_duty(3);
        do_reset();
        repeat (9) tick();
        bus.CE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (bus.OUTPUT_1 !== 1'b1) begin
                fails++; $display("FAIL ce_freeze cycle %0d: got %b want 1", i, bus.OUTPUT_1);
            end
        end
        bus.CE = 1'b1;
        tick();
        tests++;
        if (bus.OUTPUT_1 !== 1'b1) begin
            fails++; $display("FAIL ce_resume cnt2: got %b want 1", bus.OUTPUT_1);
        end
        tick();
        tests++;
        if (bus.OUTPUT_1 !== 1'b0) begin
            fails++; $display("FAIL ce_resume fall: got %b want 0", bus.OUTPUT_1);
        end
        bus.JK = 1'b0;
        repeat (5) tick();
        tests++;
        if (bus.OUTPUT_1 !== 1'b0) begin
            fails++; $display("FAIL jk_hold at wrap: got %b want 0", bus.OUTPUT_1);
        end
        bus.JK = 1'b1;
        repeat (7) tick();
        tests++;
        if (bus.OUTPUT_1 !== 1'b0) begin
            fails++; $display("FAIL jk_counter_ran cnt7: got %b want 0", bus.OUTPUT_1);
        end
        tick();
        tests++;
        if (bus.OUTPUT_1 !== 1'b1) begin
            fails++; $display("FAIL jk_counter_ran wrap: got %b want 1", bus.OUTPUT_1);
        end
        bus.CLR_JK = 1'b1;
        tick();
        bus.CLR_JK = 1'b0;
        tests++;
        if (bus.OUTPUT_1 !== 1'b0) begin
            fails++; $display("FAIL clr_jk: got %b want 0", bus.OUTPUT_1);
        end
        repeat (6) tick();
        tests++;
        if (bus.OUTPUT_1 !== 1'b0) begin
            fails++; $display("FAIL clr_jk cnt7: got %b want 0", bus.OUTPUT_1);
        end
        tick();
        tests++;
        if (bus.OUTPUT_1 !== 1'b1) begin
            fails++; $display("FAIL clr_jk counter_continued: got %b want 1", bus.OUTPUT_1);
        end
    endtask

    task automatic test_async_reset();
        bus.CE = 1'b1; bus.JK = 1'b1; bus.CLR_JK = 1'b0; bus.INPUT_4 = 1'b0;
        set_duty(5);
        do_reset();
        repeat (10) tick();
        tests++;
        if (bus.OUTPUT_1 !== 1'b1) begin
            fails++; $display("FAIL pre_async high: got %b want 1", bus.OUTPUT_1);
        end
        CLR_CNTR = 1'b1;
        #1;
        tests++;
        if (bus.OUTPUT_1 !== 1'b0) begin
            fails++; $display("FAIL async_reset immediate: got %b want 0", bus.OUTPUT_1);
        end
        #2;
        model_reset();
        CLR_CNTR = 1'b0;
        repeat (8) tick();
        for (int i = 0; i < 8; i++) begin
            logic exp_o;
            exp_o = logic'(i < 5);
            tests++;
            if (bus.OUTPUT_1 !== exp_o) begin
                fails++; $display("FAIL async_restart phase %0d: got %b want %b", i, bus.OUTPUT_1, exp_o);
            end
            tick();
        end
    endtask

    task automatic test_duty_change();
        int highs;
        int exp_first;
        bus.CE = 1'b1; bus.JK = 1'b1; bus.CLR_JK = 1'b0; bus.INPUT_4 = 1'b0;
        set_duty(3);
        do_reset();
        repeat (9) tick();
        set_duty(5);
        highs = 2;
        repeat (6) begin
            tick();
            if (bus.OUTPUT_1 === 1'b1) highs++;
        end
`ifdef PWM_DUTY_SHADOW_EN
        exp_first = 3;
`else
        exp_first = 5;
`endif
        tests++;
        if (highs !== exp_first) begin
            fails++; $display("FAIL duty_change current period highs: got %0d want %0d", highs, exp_first);
        end
        highs = 0;
        repeat (8) begin
            tick();
            if (bus.OUTPUT_1 === 1'b1) highs++;
        end
        tests++;
        if (highs !== 5) begin
            fails++; $display("FAIL duty_change next period highs: got %0d want 5", highs);
        end
    endtask

    task automatic test_random();
        bus.CE = 1'b1; bus.JK = 1'b1; bus.CLR_JK = 1'b0; bus.INPUT_4 = 1'b0;
        set_duty(4);
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.CE     = ($urandom_range(0, 99) < 85);
            bus.JK     = ($urandom_range(0, 99) < 90);
            bus.CLR_JK = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 9) == 0) set_duty(int'($urandom_range(0, 7)));
            if ($urandom_range(0, 9) == 0) bus.INPUT_4 = ~bus.INPUT_4;
            tick();
            tests++;
            if (bus.OUTPUT_1 !== model_out()) begin
                fails++; $display("FAIL random cycle %0d: got %b want %b", i, bus.OUTPUT_1, model_out());
            end
            if ($urandom_range(0, 49) == 0) begin
                CLR_CNTR = 1'b1;
                #1;
                model_reset();
                tests++;
                if (bus.OUTPUT_1 !== model_out()) begin
                    fails++; $display("FAIL random async reset cycle %0d: got %b want %b", i, bus.OUTPUT_1, model_out());
                end
                #2;
                CLR_CNTR = 1'b0;
            end
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        CLR_CNTR = 1'b1;
        model_reset();
        test_reset();
        test_pattern(3, 1'b0);
        test_pattern(0, 1'b0);
        test_pattern(7, 1'b0);
        test_pattern(3, 1'b1);
        test_controls();
        test_async_reset();
        test_duty_change();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
